clock_date_counter: RTL

- Calendar stage directly downstream of the hour-tens digit counter (which_digit = 0).
- Consumes that counter's midnight pulse and advances day/month/year/weekday for years 2000-2099.
- Outputs a binary calendar plus BCD digits for the date display.
- Provides a manual date-set path that mirrors the time-set flow.

---
 rtl/clock_date_counter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_date_counter.sv
// Calendar stage: advances day/month/year/weekday (2000-2099) on the midnight pulse, with manual date set.
// Latency: date and BCD digits update on the 3rd CLKk edge after day_pulse rises; set_load writes on the next edge.
// Backpressure: none; each day_pulse rising edge is consumed once, and in set mode it is dropped.
//
// Ports:
//   CLKk            system clock, all state on rising edge
//   RST             asynchronous active-low reset
//   day_pulse       midnight pulse from the hour-tens counter (asynchronous, may stay high)
//   set_date_enable manual date-set mode
//   set_field       0 = day, 1 = month, 2 = year, 3 = weekday
//   set_value       binary value for the selected field (clamped into range)
//   set_load        one-cycle write strobe, honoured only in set mode
//   day/month/year/weekday  binary calendar (year is offset from 2000, weekday 0 = Monday)
//   day10/day1/mon10/mon1   BCD digits of day and month
//   new_month/new_year      one-cycle rollover pulses
module clock_date_counter #(
  parameter int unsigned RESET_DAY     = 1,
  parameter int unsigned RESET_MONTH   = 1,
  parameter int unsigned RESET_YEAR    = 0,
  parameter int unsigned RESET_WEEKDAY = 5
) (
  input  logic       CLKk,
  input  logic       RST,
  input  logic       day_pulse,
  input  logic       set_date_enable,
  input  logic [1:0] set_field,
  input  logic [6:0] set_value,
  input  logic       set_load,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [2:0] weekday,
  output logic [3:0] day10,
  output logic [3:0] day1,
  output logic [3:0] mon10,
  output logic [3:0] mon1,
  output logic       new_month,
  output logic       new_year
);

  localparam logic [4:0] RST_DAY     = 5'(RESET_DAY);
  localparam logic [3:0] RST_MONTH   = 4'(RESET_MONTH);
  localparam logic [6:0] RST_YEAR    = 7'(RESET_YEAR);
  localparam logic [2:0] RST_WEEKDAY = 3'(RESET_WEEKDAY);

  localparam logic [1:0] FLD_DAY     = 2'd0;
  localparam logic [1:0] FLD_MONTH   = 2'd1;
  localparam logic [1:0] FLD_YEAR    = 2'd2;
  localparam logic [1:0] FLD_WEEKDAY = 2'd3;

  // Days in month. Every year divisible by 4 in 2000-2099 is a leap year
  // (2000 included), so the low two year bits are enough.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    logic [4:0] len;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

  function automatic logic [3:0] day_tens(input logic [4:0] v);
    logic [3:0] t;
    if (v >= 5'd30)      t = 4'd3;
    else if (v >= 5'd20) t = 4'd2;
    else if (v >= 5'd10) t = 4'd1;
    else                 t = 4'd0;
    return t;
  endfunction

  function automatic logic [3:0] day_ones(input logic [4:0] v);
    logic [4:0] r;
    if (v >= 5'd30)      r = v - 5'd30;
    else if (v >= 5'd20) r = v - 5'd20;
    else if (v >= 5'd10) r = v - 5'd10;
    else                 r = v;
    return 4'(r);
  endfunction

  function automatic logic [3:0] mon_tens(input logic [3:0] m);
    return (m >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] mon_ones(input logic [3:0] m);
    return (m >= 4'd10) ? (m - 4'd10) : m;
  endfunction

  // ---------------------------------------------------------------------------
  // Pulse capture: two-flop synchronizer plus an edge-detect flop.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic adv;

  always_ff @(posedge CLKk or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= day_pulse;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Single-cycle strobe on each synchronized rising edge; a held level
  // leaves sync2_q == sync3_q and never fires again.
  assign adv = sync2_q & ~sync3_q;

  // ---------------------------------------------------------------------------
  // Calendar state
  // ---------------------------------------------------------------------------
  logic [4:0] day_q, day_d;
  logic [3:0] month_q, month_d;
  logic [6:0] year_q, year_d;
  logic [2:0] weekday_q, weekday_d;
  logic       fix_q, fix_d;         // month/year was just written: re-clamp day
  logic       new_month_q, new_month_d;
  logic       new_year_q, new_year_d;
  logic [3:0] day10_q, day1_q, mon10_q, mon1_q;

  logic [4:0] cur_len;
  logic [4:0] eff_day;

  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    weekday_d   = weekday_q;
    fix_d       = 1'b0;
    new_month_d = 1'b0;
    new_year_d  = 1'b0;

    cur_len = month_len(month_q, year_q);

    // The cycle after a month/year write, pull day back into the new month.
    // Any advance or day write in this cycle works from the corrected day.
    eff_day = (fix_q && (day_q > cur_len)) ? cur_len : day_q;
    day_d   = eff_day;

    if (set_date_enable) begin
      // Pending advances are dropped here; the edge detector keeps running
      // so nothing stale fires when set mode is left.
      if (set_load) begin
        case (set_field)
          FLD_DAY: begin
            // Clamped against the month/year currently in effect.
            if (set_value == 7'd0)                 day_d = 5'd1;
            else if (set_value > {2'b00, cur_len}) day_d = cur_len;
            else                                   day_d = set_value[4:0];
          end
          FLD_MONTH: begin
            if (set_value == 7'd0)       month_d = 4'd1;
            else if (set_value > 7'd12)  month_d = 4'd12;
            else                         month_d = set_value[3:0];
            fix_d = 1'b1;
          end
          FLD_YEAR: begin
            year_d = (set_value > 7'd99) ? 7'd99 : set_value;
            fix_d  = 1'b1;
          end
          FLD_WEEKDAY: begin
            weekday_d = (set_value > 7'd6) ? 3'd6 : set_value[2:0];
          end
          default: ;
        endcase
      end
    end else if (adv) begin
      weekday_d = (weekday_q >= 3'd6) ? 3'd0 : weekday_q + 3'd1;
      if (eff_day < cur_len) begin
        day_d = eff_day + 5'd1;
      end else begin
        day_d       = 5'd1;
        new_month_d = 1'b1;
        if (month_q >= 4'd12) begin
          month_d    = 4'd1;
          new_year_d = 1'b1;
          year_d     = (year_q >= 7'd99) ? 7'd0 : year_q + 7'd1;
        end else begin
          month_d = month_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLKk or negedge RST) begin
    if (!RST) begin
      day_q       <= RST_DAY;
      month_q     <= RST_MONTH;
      year_q      <= RST_YEAR;
      weekday_q   <= RST_WEEKDAY;
      fix_q       <= 1'b0;
      new_month_q <= 1'b0;
      new_year_q  <= 1'b0;
      day10_q     <= day_tens(RST_DAY);
      day1_q      <= day_ones(RST_DAY);
      mon10_q     <= mon_tens(RST_MONTH);
      mon1_q      <= mon_ones(RST_MONTH);
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      weekday_q   <= weekday_d;
      fix_q       <= fix_d;
      new_month_q <= new_month_d;
      new_year_q  <= new_year_d;
      // Digits are built from next-state values so they change on the
      // same edge as the binary fields.
      day10_q     <= day_tens(day_d);
      day1_q      <= day_ones(day_d);
      mon10_q     <= mon_tens(month_d);
      mon1_q      <= mon_ones(month_d);
    end
  end

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign weekday   = weekday_q;
  assign day10     = day10_q;
  assign day1      = day1_q;
  assign mon10     = mon10_q;
  assign mon1      = mon1_q;
  assign new_month = new_month_q;
  assign new_year  = new_year_q;

endmodule
